dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-ported 16-bit data memory between requester 0 (core load/store unit) and requester 1 (debug/loader port).
- Sits between the requesters and the data memory and drives its addr/wdata/write_en/read pins.
- Arbitration is round-robin per access, with an optional bounded lock (burst ownership).
- Read data is registered and returned one cycle after grant.

---
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between two requesters,
// with bounded burst ownership (lock) and registered read-data return.
module dmem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r0_lock,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              r1_lock,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t             state_reg, state_next;
    logic               last_gnt_reg, last_gnt_next;
    logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic               r0_rvalid_reg, r1_rvalid_reg;
    logic [DATA_W-1:0]  r0_rdata_reg, r1_rdata_reg;

    logic pick0, pick1, owned, sel_lock, sel_we;

    // Owner keeps the memory while it requests; otherwise fall back to round-robin.
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        owned = 1'b0;
        if (state_reg == OWN0 && r0_req) begin
            pick0 = 1'b1;
            owned = 1'b1;
        end else if (state_reg == OWN1 && r1_req) begin
            pick1 = 1'b1;
            owned = 1'b1;
        end else if (r0_req && r1_req) begin
            if (last_gnt_reg) pick0 = 1'b1;
            else              pick1 = 1'b1;
        end else if (r0_req) begin
            pick0 = 1'b1;
        end else if (r1_req) begin
            pick1 = 1'b1;
        end
    end

    assign r0_gnt = pick0 & rst_n;
    assign r1_gnt = pick1 & rst_n;

    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        sel_lock        = 1'b0;
        sel_we          = 1'b0;
        if (r0_gnt) begin
            mem_access_addr = r0_addr;
            mem_write_data  = r0_wdata;
            sel_we          = r0_we;
            sel_lock        = r0_lock;
        end else if (r1_gnt) begin
            mem_access_addr = r1_addr;
            mem_write_data  = r1_wdata;
            sel_we          = r1_we;
            sel_lock        = r1_lock;
        end
        if (r0_gnt || r1_gnt) begin
            mem_write_en = sel_we;
            mem_read     = ~sel_we;
        end
    end

    always_comb begin
        state_next    = IDLE;
        beat_cnt_next = '0;
        last_gnt_next = last_gnt_reg;
        if (r0_gnt || r1_gnt) begin
            last_gnt_next = r1_gnt;
            if (owned) begin
                // Release after the final permitted beat even if lock is still held.
                if (sel_lock && (beat_cnt_reg + CNT_W'(1)) != CNT_W'(MAX_BURST)) begin
                    state_next    = state_reg;
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                end
            end else if (sel_lock && MAX_BURST > 1) begin
                state_next    = r1_gnt ? OWN1 : OWN0;
                beat_cnt_next = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            last_gnt_reg  <= 1'b1;
            beat_cnt_reg  <= '0;
            r0_rvalid_reg <= 1'b0;
            r1_rvalid_reg <= 1'b0;
            r0_rdata_reg  <= '0;
            r1_rdata_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            last_gnt_reg  <= last_gnt_next;
            beat_cnt_reg  <= beat_cnt_next;
            r0_rvalid_reg <= r0_gnt & ~r0_we;
            r1_rvalid_reg <= r1_gnt & ~r1_we;
            if (r0_gnt && !r0_we) r0_rdata_reg <= mem_read_data;
            if (r1_gnt && !r1_we) r1_rdata_reg <= mem_read_data;
        end
    end

    assign r0_rvalid = r0_rvalid_reg;
    assign r1_rvalid = r1_rvalid_reg;
    assign r0_rdata  = r0_rdata_reg;
    assign r1_rdata  = r1_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scenario bench for dmem_arbiter: behavioural memory, expected read data queued
// at grant time and matched against rvalid/rdata one cycle later.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_req = 0, r0_we = 0, r0_lock = 0;
    logic [15:0] r0_addr = 0, r0_wdata = 0;
    logic        r1_req = 0, r1_we = 0, r1_lock = 0;
    logic [15:0] r1_addr = 0, r1_wdata = 0;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [15:0] r0_rdata, r1_rdata;
    logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cycle = 0;
    logic [15:0] mem [0:255];

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_lock(r0_lock), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_lock(r1_lock), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_access_addr[7:0]];
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (mem_write_en) mem[mem_access_addr[7:0]] <= mem_write_data;
    end

    // Scoreboard: any rvalid, or any entry due this cycle, is compared.
    always @(negedge clk) begin : monitor
        logic exp_v;
        exp_t e;
        exp_v = (q0.size() > 0) && (q0[0].due == cycle);
        if (exp_v || r0_rvalid === 1'b1) begin
            compared++;
            if (r0_rvalid !== exp_v) begin
                mismatched++;
                $display("FAIL r0_rvalid cycle %0d: got %b want %b", cycle, r0_rvalid, exp_v);
                if (exp_v) void'(q0.pop_front());
            end else begin
                e = q0.pop_front();
                compared++;
                if (r0_rdata !== e.data) begin
                    mismatched++;
                    $display("FAIL r0_rdata cycle %0d: got %h want %h", cycle, r0_rdata, e.data);
                end
            end
        end
        exp_v = (q1.size() > 0) && (q1[0].due == cycle);
        if (exp_v || r1_rvalid === 1'b1) begin
            compared++;
            if (r1_rvalid !== exp_v) begin
                mismatched++;
                $display("FAIL r1_rvalid cycle %0d: got %b want %b", cycle, r1_rvalid, exp_v);
                if (exp_v) void'(q1.pop_front());
            end else begin
                e = q1.pop_front();
                compared++;
                if (r1_rdata !== e.data) begin
                    mismatched++;
                    $display("FAIL r1_rdata cycle %0d: got %h want %h", cycle, r1_rdata, e.data);
                end
            end
        end
    end

    task automatic drive(input int who, input logic req, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata, input logic lock);
        if (who == 0) begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_lock = lock;
        end else begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_lock = lock;
        end
    endtask

    task automatic push(input int who, input logic [15:0] data);
        exp_t e;
        e.data = data;
        e.due  = cycle + 1;
        if (who == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1, 1, 16'h0011, 16'hFFFF, 1);
        drive(1, 1, 0, 16'h0022, 16'h0000, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            compared += 4;
            if ({r0_gnt, r1_gnt} !== 2'b00) begin
                mismatched++; $display("FAIL reset_gnt: got %b want 00", {r0_gnt, r1_gnt});
            end
            if ({mem_write_en, mem_read} !== 2'b00) begin
                mismatched++; $display("FAIL reset_mem_ctl: got %b want 00", {mem_write_en, mem_read});
            end
            if (mem_access_addr !== 16'h0) begin
                mismatched++; $display("FAIL reset_addr: got %h want 0000", mem_access_addr);
            end
            if (mem_write_data !== 16'h0) begin
                mismatched++; $display("FAIL reset_wdata: got %h want 0000", mem_write_data);
            end
            next_cycle();
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        compared += 2;
        if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
            mismatched++; $display("FAIL reset_rvalid: got %b want 00", {r0_rvalid, r1_rvalid});
        end
        if (r0_rdata !== 16'h0 || r1_rdata !== 16'h0) begin
            mismatched++; $display("FAIL reset_rdata: got %h/%h want 0000/0000", r0_rdata, r1_rdata);
        end
        next_cycle();
    endtask

    task automatic test_alternate();
        int exp_w = 0;
        drive(0, 1, 0, 16'h0003, 0, 0);
        drive(1, 1, 0, 16'h0007, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            compared++;
            if ({r0_gnt, r1_gnt} !== ((exp_w == 0) ? 2'b10 : 2'b01)) begin
                mismatched++;
                $display("FAIL alternate beat %0d: got r0/r1 gnt %b want winner r%0d", i, {r0_gnt, r1_gnt}, exp_w);
            end
            push(exp_w, (exp_w == 0) ? mem[3] : mem[7]);
            exp_w ^= 1;
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        next_cycle();
    endtask

    task automatic test_single_read();
        drive(0, 1, 0, 16'h0003, 0, 0);
        @(negedge clk);
        compared += 3;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            mismatched++; $display("FAIL read_gnt: got %b want 10", {r0_gnt, r1_gnt});
        end
        if ({mem_read, mem_write_en} !== 2'b10) begin
            mismatched++; $display("FAIL read_mem_ctl: got %b want 10", {mem_read, mem_write_en});
        end
        if (mem_access_addr !== 16'h0003) begin
            mismatched++; $display("FAIL read_addr: got %h want 0003", mem_access_addr);
        end
        push(0, 16'h00A5);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        compared += 2;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 16'h00A5) begin
            mismatched++; $display("FAIL read_resp: got v=%b d=%h want v=1 d=00a5", r0_rvalid, r0_rdata);
        end
        if (r1_rvalid !== 1'b0) begin
            mismatched++; $display("FAIL read_r1_quiet: got %b want 0", r1_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_read_after_write();
        drive(1, 1, 1, 16'h0005, 16'h1234, 0);
        @(negedge clk);
        compared += 3;
        if ({r0_gnt, r1_gnt} !== 2'b01) begin
            mismatched++; $display("FAIL raw_wr_gnt: got %b want 01", {r0_gnt, r1_gnt});
        end
        if ({mem_write_en, mem_read} !== 2'b10) begin
            mismatched++; $display("FAIL raw_wr_ctl: got %b want 10", {mem_write_en, mem_read});
        end
        if (mem_access_addr !== 16'h0005 || mem_write_data !== 16'h1234) begin
            mismatched++; $display("FAIL raw_wr_bus: got %h/%h want 0005/1234", mem_access_addr, mem_write_data);
        end
        next_cycle();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 16'h0005, 0, 0);
        @(negedge clk);
        compared++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            mismatched++; $display("FAIL raw_rd_gnt: got %b want 10", {r0_gnt, r1_gnt});
        end
        push(0, 16'h1234);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();
    endtask

    task automatic test_burst();
        drive(0, 1, 0, 16'h0003, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 16'(16 + i), 16'(16'hB000 + i), 1);
            @(negedge clk);
            compared++;
            if (i < 4) begin
                if ({r0_gnt, r1_gnt} !== 2'b01) begin
                    mismatched++; $display("FAIL burst beat %0d: got %b want 01", i, {r0_gnt, r1_gnt});
                end
            end else begin
                if ({r0_gnt, r1_gnt} !== 2'b10) begin
                    mismatched++; $display("FAIL burst release: got %b want 10", {r0_gnt, r1_gnt});
                end
                push(0, mem[3]);
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        compared++;
        if (mem[19] !== 16'hB003) begin
            mismatched++; $display("FAIL burst_last_write: got %h want b003", mem[19]);
        end
        next_cycle();
    endtask

    task automatic test_drop_ownership();
        drive(0, 1, 1, 16'h0008, 16'h0808, 1);
        @(negedge clk);
        compared++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            mismatched++; $display("FAIL drop_own_gnt: got %b want 10", {r0_gnt, r1_gnt});
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 16'h0007, 0, 0);
        @(negedge clk);
        compared += 2;
        if ({r0_gnt, r1_gnt} !== 2'b01) begin
            mismatched++; $display("FAIL drop_handover: got %b want 01", {r0_gnt, r1_gnt});
        end
        if (mem_access_addr !== 16'h0007) begin
            mismatched++; $display("FAIL drop_addr: got %h want 0007", mem_access_addr);
        end
        push(1, mem[7]);
        next_cycle();
        drive(0, 1, 0, 16'h0003, 0, 0);
        @(negedge clk);
        compared++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            mismatched++; $display("FAIL drop_next_rr: got %b want 10", {r0_gnt, r1_gnt});
        end
        push(0, mem[3]);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        drive(0, 1, 0, 16'h0003, 0, 0);
        drive(1, 1, 0, 16'h0007, 0, 1);
        @(negedge clk);
        compared++;
        if ({r0_gnt, r1_gnt} !== 2'b01) begin
            mismatched++; $display("FAIL mid_lock_gnt: got %b want 01", {r0_gnt, r1_gnt});
        end
        push(1, mem[7]);
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        compared += 2;
        if ({r0_gnt, r1_gnt} !== 2'b00) begin
            mismatched++; $display("FAIL mid_rst_gnt: got %b want 00", {r0_gnt, r1_gnt});
        end
        if ({mem_write_en, mem_read} !== 2'b00 || mem_access_addr !== 16'h0) begin
            mismatched++;
            $display("FAIL mid_rst_mem: got ctl %b addr %h want 00/0000", {mem_write_en, mem_read}, mem_access_addr);
        end
        next_cycle();
        rst_n = 1'b1;
        drive(1, 1, 0, 16'h0007, 0, 0);
        @(negedge clk);
        compared += 2;
        if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
            mismatched++; $display("FAIL mid_rst_rvalid: got %b want 00", {r0_rvalid, r1_rvalid});
        end
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            mismatched++; $display("FAIL mid_rst_rr: got %b want 10", {r0_gnt, r1_gnt});
        end
        push(0, mem[3]);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5A00;
        mem[3] = 16'h00A5;
        test_reset();
        test_alternate();
        test_single_read();
        test_read_after_write();
        test_burst();
        test_drop_ownership();
        test_reset_mid_burst();
        @(negedge clk);
        compared++;
        if (q0.size() != 0 || q1.size() != 0) begin
            mismatched++; $display("FAIL pending_reads: got %0d/%0d left want 0/0", q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
